// File: rtl/biquad_coef_sequencer.sv
// Shadow bank of 8x5 biquad coefficients, pushed band by band into the chain.
// Optional handshake watchdog: define COEF_SEQ_TIMEOUT_EN.
module biquad_coef_sequencer #(
    parameter int COEF_W         = 18,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              wr_en,
    input  logic [2:0]        wr_band,
    input  logic [2:0]        wr_sel,
    input  logic [COEF_W-1:0] wr_data,
    input  logic              commit,
    input  logic              coefficients_updated,
    output logic [2:0]        biquad_index,
    output logic              push_coefficients,
    output logic [COEF_W-1:0] b0,
    output logic [COEF_W-1:0] b1,
    output logic [COEF_W-1:0] b2,
    output logic [COEF_W-1:0] a1,
    output logic [COEF_W-1:0] a2,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [1:0] {
        IDLE,
        PUSH,
        RELEASE
    } state_t;

    localparam logic [COEF_W-1:0] UNITY = COEF_W'(65536);

    state_t            state;
    logic [COEF_W-1:0] shadow [8][5];
    logic [7:0]        dirty;
    logic              pending;

    logic       wr_ok;
    logic       any_dirty;
    logic       up_valid;
    logic [2:0] low_idx;
    logic [2:0] up_idx;

    logic       go_push;
    logic       go_idle;
    logic       abort;
    logic       take_pend;
    logic       tmo;
    logic [2:0] nxt_idx;

    assign wr_ok     = wr_en && (wr_sel <= 3'd4);
    assign any_dirty = |dirty;

    // Lowest dirty band overall, and lowest dirty band above the current one.
    always_comb begin
        low_idx  = 3'd0;
        up_idx   = 3'd0;
        up_valid = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (dirty[i]) begin
                low_idx = 3'(i);
            end
            if (dirty[i] && (3'(i) > biquad_index)) begin
                up_idx   = 3'(i);
                up_valid = 1'b1;
            end
        end
    end

`ifdef COEF_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    assign tmo = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt   <= '0;
            error <= 1'b0;
        end else begin
            if (go_push || (state == PUSH && coefficients_updated)) begin
                cnt <= '0;
            end else if (state != IDLE) begin
                cnt <= cnt + 1'b1;
            end
            if (abort) begin
                error <= 1'b1;
            end else if (state == IDLE && commit) begin
                error <= 1'b0;
            end
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;

    assign tmo   = 1'b0;
    assign error = 1'b0;
`endif

    always_comb begin
        go_push   = 1'b0;
        go_idle   = 1'b0;
        abort     = 1'b0;
        take_pend = 1'b0;
        nxt_idx   = biquad_index;
        unique case (state)
            IDLE: begin
                if (commit) begin
                    if (any_dirty) begin
                        go_push = 1'b1;
                        nxt_idx = low_idx;
                    end else begin
                        go_idle = 1'b1;
                    end
                end
            end
            PUSH: begin
                if (!coefficients_updated && tmo) begin
                    abort = 1'b1;
                end
            end
            RELEASE: begin
                if (!coefficients_updated) begin
                    if (up_valid) begin
                        go_push = 1'b1;
                        nxt_idx = up_idx;
                    end else if ((pending || commit) && any_dirty) begin
                        // Wrap around to pick up bands dirtied behind us.
                        go_push   = 1'b1;
                        take_pend = 1'b1;
                        nxt_idx   = low_idx;
                    end else begin
                        go_idle = 1'b1;
                    end
                end else if (tmo) begin
                    abort = 1'b1;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state             <= IDLE;
            dirty             <= 8'hFF;
            pending           <= 1'b0;
            biquad_index      <= 3'd0;
            push_coefficients <= 1'b0;
            b0                <= '0;
            b1                <= '0;
            b2                <= '0;
            a1                <= '0;
            a2                <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 5; j++) begin
                    shadow[i][j] <= (j == 0) ? UNITY : '0;
                end
            end
        end else begin
            done <= 1'b0;
            if (wr_ok) begin
                shadow[wr_band][wr_sel] <= wr_data;
            end
            // A write landing on the acknowledge cycle keeps the band dirty.
            if (state == PUSH && coefficients_updated) begin
                dirty[biquad_index] <= 1'b0;
            end
            if (wr_ok) begin
                dirty[wr_band] <= 1'b1;
            end
            if (state != IDLE && commit) begin
                pending <= 1'b1;
            end
            if (take_pend || go_idle || abort) begin
                pending <= 1'b0;
            end
            if (go_push) begin
                state             <= PUSH;
                biquad_index      <= nxt_idx;
                push_coefficients <= 1'b1;
                busy              <= 1'b1;
                b0                <= shadow[nxt_idx][0];
                b1                <= shadow[nxt_idx][1];
                b2                <= shadow[nxt_idx][2];
                a1                <= shadow[nxt_idx][3];
                a2                <= shadow[nxt_idx][4];
            end else if (state == PUSH && coefficients_updated) begin
                state             <= RELEASE;
                push_coefficients <= 1'b0;
            end else if (go_idle || abort) begin
                state             <= IDLE;
                push_coefficients <= 1'b0;
                busy              <= 1'b0;
                done              <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_biquad_coef_sequencer.sv
// Bench for biquad_coef_sequencer: cycle model plus directed scenarios.
// Build with COEF_SEQ_TIMEOUT_EN to exercise the watchdog (TIMEOUT_CYCLES=16).
module tb_biquad_coef_sequencer;

    localparam int W   = 18;
    localparam int TMO = 16;
`ifdef COEF_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam logic [W-1:0] UNITY   = 18'd65536;
    localparam logic [W-1:0] NEG1234 = 18'h3FB2E;

    logic         Clk;
    logic         Reset;
    logic         wr_en;
    logic [2:0]   wr_band;
    logic [2:0]   wr_sel;
    logic [W-1:0] wr_data;
    logic         commit;
    logic         coefficients_updated;
    logic [2:0]   biquad_index;
    logic         push_coefficients;
    logic [W-1:0] b0, b1, b2, a1, a2;
    logic         busy;
    logic         done;
    logic         error;

    biquad_coef_sequencer #(
        .COEF_W         (W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .Clk                  (Clk),
        .Reset                (Reset),
        .wr_en                (wr_en),
        .wr_band              (wr_band),
        .wr_sel               (wr_sel),
        .wr_data              (wr_data),
        .commit               (commit),
        .coefficients_updated (coefficients_updated),
        .biquad_index         (biquad_index),
        .push_coefficients    (push_coefficients),
        .b0                   (b0),
        .b1                   (b1),
        .b2                   (b2),
        .a1                   (a1),
        .a2                   (a2),
        .busy                 (busy),
        .done                 (done),
        .error                (error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_total = 0;
    int n_pass  = 0;

    // Model: mode 0 = idle, 1 = pushing, 2 = waiting for ack release.
    logic [W-1:0] m_bank [8][5];
    logic [W-1:0] m_out  [5];
    bit   [7:0]   m_dirty;
    int           m_mode;
    int           m_idx;
    int           m_cnt;
    bit           m_pend;
    bit           m_err;
    bit           m_done;

    bit           auto_ack = 1'b0;
    bit           prev_push = 1'b0;
    int           done_cnt = 0;
    int           q_idx[$];
    logic [W-1:0] q_b0[$];
    logic [W-1:0] q_b1[$];
    logic [W-1:0] q_b2[$];
    logic [W-1:0] q_a1[$];
    logic [W-1:0] q_a2[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 5; j++) begin
                m_bank[i][j] = (j == 0) ? UNITY : '0;
            end
        end
        for (int j = 0; j < 5; j++) m_out[j] = '0;
        m_dirty = 8'hFF;
        m_mode  = 0;
        m_idx   = 0;
        m_cnt   = 0;
        m_pend  = 1'b0;
        m_err   = 1'b0;
        m_done  = 1'b0;
    endtask

    function automatic int first_dirty(input int from);
        for (int i = from; i < 8; i++) begin
            if (m_dirty[i]) return i;
        end
        return -1;
    endfunction

    task automatic enter_push(input int k);
        m_mode = 1;
        m_idx  = k;
        m_cnt  = 0;
        for (int j = 0; j < 5; j++) m_out[j] = m_bank[k][j];
    endtask

    task automatic model_abort();
        m_mode = 0;
        m_err  = 1'b1;
        m_pend = 1'b0;
        m_done = 1'b1;
    endtask

    task automatic model_step();
        bit wr;
        int k;
        wr     = wr_en && (wr_sel <= 3'd4);
        m_done = 1'b0;
        if (Reset) begin
            model_reset();
            return;
        end
        case (m_mode)
            0: begin
                if (commit) begin
                    m_err = 1'b0;
                    k = first_dirty(0);
                    if (k >= 0) enter_push(k);
                    else m_done = 1'b1;
                end
            end
            1: begin
                if (commit) m_pend = 1'b1;
                if (coefficients_updated) begin
                    m_dirty[m_idx] = 1'b0;
                    m_mode = 2;
                    m_cnt  = 0;
                end else if (TMO_EN && m_cnt == TMO - 1) begin
                    model_abort();
                end else begin
                    m_cnt++;
                end
            end
            default: begin
                if (commit) m_pend = 1'b1;
                if (!coefficients_updated) begin
                    k = first_dirty(m_idx + 1);
                    if (k >= 0) begin
                        enter_push(k);
                    end else if (m_pend && first_dirty(0) >= 0) begin
                        m_pend = 1'b0;
                        enter_push(first_dirty(0));
                    end else begin
                        m_pend = 1'b0;
                        m_mode = 0;
                        m_done = 1'b1;
                    end
                end else if (TMO_EN && m_cnt == TMO - 1) begin
                    model_abort();
                end else begin
                    m_cnt++;
                end
            end
        endcase
        if (wr) begin
            m_bank[wr_band][wr_sel] = wr_data;
            m_dirty[wr_band] = 1'b1;
        end
    endtask

    task automatic compare();
        chk("push", 32'(push_coefficients), 32'(m_mode == 1));
        chk("busy", 32'(busy), 32'(m_mode != 0));
        chk("done", 32'(done), 32'(m_done));
        chk("error", 32'(error), 32'(m_err));
        chk("index", 32'(biquad_index), 32'(m_idx));
        chk("b0", 32'(b0), 32'(m_out[0]));
        chk("b1", 32'(b1), 32'(m_out[1]));
        chk("b2", 32'(b2), 32'(m_out[2]));
        chk("a1", 32'(a1), 32'(m_out[3]));
        chk("a2", 32'(a2), 32'(m_out[4]));
        chk("done_busy_excl", 32'(done & busy), 32'd0);
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        compare();
        if (push_coefficients && !prev_push) begin
            q_idx.push_back(int'(biquad_index));
            q_b0.push_back(b0);
            q_b1.push_back(b1);
            q_b2.push_back(b2);
            q_a1.push_back(a1);
            q_a2.push_back(a2);
        end
        prev_push = push_coefficients;
        if (done) done_cnt++;
        if (auto_ack) coefficients_updated = push_coefficients;
    endtask

    task automatic clear_log();
        q_idx.delete();
        q_b0.delete();
        q_b1.delete();
        q_b2.delete();
        q_a1.delete();
        q_a2.delete();
    endtask

    task automatic write(input int band, input int sel,
                         input logic [W-1:0] d);
        wr_en   = 1'b1;
        wr_band = 3'(band);
        wr_sel  = 3'(sel);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic run_until_done(input string name, input int budget);
        int base;
        int n;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(done_cnt != base), 32'd1);
    endtask

    task automatic start_auto();
        auto_ack = 1'b1;
        coefficients_updated = push_coefficients;
    endtask

    initial begin
        int base;
        int n;
        Reset = 1'b1;
        wr_en = 1'b0;
        wr_band = '0;
        wr_sel = '0;
        wr_data = '0;
        commit = 1'b0;
        coefficients_updated = 1'b0;
        model_reset();

        tick();
        tick();
        Reset = 1'b0;
        chk("rst_push", 32'(push_coefficients), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_b0", 32'(b0), 32'd0);
        tick();

        // Full push of the reset bank.
        start_auto();
        clear_log();
        base = done_cnt;
        pulse_commit();
        chk("first_push_idx", 32'(biquad_index), 32'd0);
        chk("first_push_b0", 32'(b0), 32'(UNITY));
        run_until_done("wait_full", 200);
        repeat (3) tick();
        chk("full_done_once", 32'(done_cnt - base), 32'd1);
        chk("full_count", 32'(q_idx.size()), 32'd8);
        for (int i = 0; i < q_idx.size(); i++) begin
            chk("full_idx", 32'(q_idx[i]), 32'(i));
            chk("full_b0", 32'(q_b0[i]), 32'(UNITY));
            chk("full_a2", 32'(q_a2[i]), 32'd0);
        end

        // Nothing dirty, and sel 5 writes are ignored.
        write(6, 5, 18'd123);
        pulse_commit();
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_busy", 32'(busy), 32'd0);
        tick();

        // Two scattered writes.
        clear_log();
        write(5, 1, NEG1234);
        write(2, 4, 18'd777);
        pulse_commit();
        run_until_done("wait_two", 100);
        chk("two_count", 32'(q_idx.size()), 32'd2);
        if (q_idx.size() == 2) begin
            chk("two_idx0", 32'(q_idx[0]), 32'd2);
            chk("two_a2", 32'(q_a2[0]), 32'd777);
            chk("two_idx1", 32'(q_idx[1]), 32'd5);
            chk("two_b1", 32'(q_b1[1]), 32'(NEG1234));
            chk("two_b0", 32'(q_b0[1]), 32'(UNITY));
        end
        tick();

        // Writes during an in-flight push of band 3.
        auto_ack = 1'b0;
        coefficients_updated = 1'b0;
        write(3, 2, 18'd9);
        pulse_commit();
        chk("mid_idx", 32'(biquad_index), 32'd3);
        write(1, 3, 18'd5);
        coefficients_updated = 1'b1;
        write(3, 0, 18'd100);
        chk("mid_b0_stable", 32'(b0), 32'(UNITY));
        chk("mid_b2", 32'(b2), 32'd9);
        coefficients_updated = 1'b0;
        tick();
        chk("mid_end_done", 32'(done), 32'd1);
        clear_log();
        start_auto();
        pulse_commit();
        run_until_done("wait_mid", 100);
        chk("mid_count", 32'(q_idx.size()), 32'd2);
        if (q_idx.size() == 2) begin
            chk("mid_idx0", 32'(q_idx[0]), 32'd1);
            chk("mid_a1", 32'(q_a1[0]), 32'd5);
            chk("mid_idx1", 32'(q_idx[1]), 32'd3);
            chk("mid_b0_new", 32'(q_b0[1]), 32'd100);
        end
        tick();

        // Commit during RELEASE of band 6, band 0 dirtied behind it.
        auto_ack = 1'b0;
        coefficients_updated = 1'b0;
        clear_log();
        write(6, 0, 18'd11);
        write(7, 0, 18'd22);
        base = done_cnt;
        pulse_commit();
        write(0, 3, 18'd33);
        coefficients_updated = 1'b1;
        tick();
        pulse_commit();
        start_auto();
        run_until_done("wait_pend", 100);
        repeat (4) tick();
        chk("pend_done_once", 32'(done_cnt - base), 32'd1);
        chk("pend_count", 32'(q_idx.size()), 32'd3);
        if (q_idx.size() == 3) begin
            chk("pend_idx0", 32'(q_idx[0]), 32'd6);
            chk("pend_idx1", 32'(q_idx[1]), 32'd7);
            chk("pend_b0_7", 32'(q_b0[1]), 32'd22);
            chk("pend_idx2", 32'(q_idx[2]), 32'd0);
            chk("pend_a1_0", 32'(q_a1[2]), 32'd33);
        end

        // Acknowledge held low.
        auto_ack = 1'b0;
        coefficients_updated = 1'b0;
        clear_log();
        write(4, 0, 18'd44);
        pulse_commit();
        n = 1;
        if (TMO_EN) begin
            while (push_coefficients && n < 100) begin
                tick();
                if (push_coefficients) n++;
            end
            chk("tmo_push_cycles", 32'(n), 32'(TMO));
            chk("tmo_error", 32'(error), 32'd1);
            chk("tmo_done", 32'(done), 32'd1);
            pulse_commit();
            chk("tmo_err_clear", 32'(error), 32'd0);
            chk("tmo_redo_idx", 32'(biquad_index), 32'd4);
            start_auto();
            run_until_done("wait_tmo", 50);
        end else begin
            repeat (40) tick();
            chk("hold_push", 32'(push_coefficients), 32'd1);
            chk("hold_error", 32'(error), 32'd0);
            start_auto();
            run_until_done("wait_hold", 50);
        end
        chk("tmo_b0", 32'(q_b0[q_b0.size()-1]), 32'd44);
        tick();

        // Reset in the middle of a push.
        auto_ack = 1'b0;
        coefficients_updated = 1'b0;
        write(2, 0, 18'd5);
        pulse_commit();
        chk("rp_push", 32'(push_coefficients), 32'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("rp_push_drop", 32'(push_coefficients), 32'd0);
        chk("rp_busy", 32'(busy), 32'd0);
        chk("rp_idx", 32'(biquad_index), 32'd0);
        chk("rp_b0", 32'(b0), 32'd0);
        clear_log();
        start_auto();
        pulse_commit();
        run_until_done("wait_rp", 200);
        chk("rp_count", 32'(q_idx.size()), 32'd8);
        for (int i = 0; i < q_idx.size(); i++) begin
            chk("rp_idx_seq", 32'(q_idx[i]), 32'(i));
            chk("rp_b0_seq", 32'(q_b0[i]), 32'(UNITY));
        end
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
